// File: rtl/dcache_lsu_issue_if.sv
// Bundle between the AGUs/ctrl and the DCache stage-1 requester.
// The slave modport is the issue block; master is the environment driving it.
interface dcache_lsu_issue_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 3
);
    logic              DcacheStop;
    logic              DcacheFlash;
    logic              AguLoadValid;
    logic [ADDR_W-1:0] AguLoadAddr;
    logic              AguLoadReady;
    logic              AguStoreValid;
    logic [ADDR_W-1:0] AguStoreAddr;
    logic              AguStoreReady;
    logic              LoadAble;
    logic              LoadReq;
    logic [ADDR_W-1:0] LoadPhyAddr;
    logic              StoreAble;
    logic              StoreReq;
    logic [ADDR_W-1:0] StorePhyAddr;
    logic [CNT_W-1:0]  LoadCount;
    logic [CNT_W-1:0]  StoreCount;

    modport master (
        output DcacheStop, DcacheFlash,
        output AguLoadValid, AguLoadAddr, AguStoreValid, AguStoreAddr,
        output LoadReq, StoreReq,
        input  AguLoadReady, AguStoreReady,
        input  LoadAble, LoadPhyAddr, StoreAble, StorePhyAddr,
        input  LoadCount, StoreCount
    );

    modport slave (
        input  DcacheStop, DcacheFlash,
        input  AguLoadValid, AguLoadAddr, AguStoreValid, AguStoreAddr,
        input  LoadReq, StoreReq,
        output AguLoadReady, AguStoreReady,
        output LoadAble, LoadPhyAddr, StoreAble, StorePhyAddr,
        output LoadCount, StoreCount
    );
endinterface

// File: rtl/dcache_lsu_issue.sv
// Load/store address issue queues feeding DCache stage 1, with stall, flush
// and store-to-load word-address hazard blocking.
module dcache_lsu_issue #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 3
) (
    input  logic               Clk,
    input  logic               Rest,
    dcache_lsu_issue_if.slave  bus
);
    localparam int unsigned       PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0]  FULL  = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] ld_mem_q [DEPTH];
    logic [ADDR_W-1:0] st_mem_q [DEPTH];
    logic [PTR_W-1:0]  ld_rd_q, ld_rd_d, ld_wr_q, ld_wr_d;
    logic [PTR_W-1:0]  st_rd_q, st_rd_d, st_wr_q, st_wr_d;
    logic [CNT_W-1:0]  ld_cnt_q, ld_cnt_d, st_cnt_q, st_cnt_d;

    logic              ld_head_vld, st_head_vld, issue_ok, hazard;
    logic              ld_enq, ld_deq, st_enq, st_deq;
    logic [ADDR_W-1:0] ld_head, st_head;
    logic [PTR_W-1:0]  st_off;

    assign ld_head_vld = (ld_cnt_q != '0);
    assign st_head_vld = (st_cnt_q != '0);
    assign ld_head     = ld_head_vld ? ld_mem_q[ld_rd_q] : '0;
    assign st_head     = st_head_vld ? st_mem_q[st_rd_q] : '0;
    assign issue_ok    = ~bus.DcacheStop & ~bus.DcacheFlash;

    // Any live store entry, including the one issuing now, blocks a same-word load.
    always_comb begin
        hazard = 1'b0;
        st_off = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            st_off = PTR_W'(i) - st_rd_q;
            if ((CNT_W'(st_off) < st_cnt_q) &&
                (st_mem_q[i][ADDR_W-1:2] == ld_head[ADDR_W-1:2])) begin
                hazard = 1'b1;
            end
        end
    end

    assign bus.AguLoadReady  = (ld_cnt_q != FULL);
    assign bus.AguStoreReady = (st_cnt_q != FULL);
    assign bus.LoadAble      = ld_head_vld & issue_ok & ~hazard;
    assign bus.StoreAble     = st_head_vld & issue_ok;
    assign bus.LoadPhyAddr   = ld_head;
    assign bus.StorePhyAddr  = st_head;
    assign bus.LoadCount     = ld_cnt_q;
    assign bus.StoreCount    = st_cnt_q;

    assign ld_enq = bus.AguLoadValid & bus.AguLoadReady & ~bus.DcacheFlash;
    assign st_enq = bus.AguStoreValid & bus.AguStoreReady & ~bus.DcacheFlash;
    assign ld_deq = bus.LoadAble & bus.LoadReq;
    assign st_deq = bus.StoreAble & bus.StoreReq;

    always_comb begin
        ld_rd_d  = ld_rd_q;
        ld_wr_d  = ld_wr_q;
        ld_cnt_d = ld_cnt_q;
        st_rd_d  = st_rd_q;
        st_wr_d  = st_wr_q;
        st_cnt_d = st_cnt_q;
        if (bus.DcacheFlash) begin
            ld_rd_d  = '0;
            ld_wr_d  = '0;
            ld_cnt_d = '0;
            st_rd_d  = '0;
            st_wr_d  = '0;
            st_cnt_d = '0;
        end else begin
            if (ld_enq) ld_wr_d = ld_wr_q + PTR_W'(1);
            if (ld_deq) ld_rd_d = ld_rd_q + PTR_W'(1);
            if (st_enq) st_wr_d = st_wr_q + PTR_W'(1);
            if (st_deq) st_rd_d = st_rd_q + PTR_W'(1);
            case ({ld_enq, ld_deq})
                2'b10:   ld_cnt_d = ld_cnt_q + CNT_W'(1);
                2'b01:   ld_cnt_d = ld_cnt_q - CNT_W'(1);
                default: ld_cnt_d = ld_cnt_q;
            endcase
            case ({st_enq, st_deq})
                2'b10:   st_cnt_d = st_cnt_q + CNT_W'(1);
                2'b01:   st_cnt_d = st_cnt_q - CNT_W'(1);
                default: st_cnt_d = st_cnt_q;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rest) begin
            ld_rd_q  <= '0;
            ld_wr_q  <= '0;
            ld_cnt_q <= '0;
            st_rd_q  <= '0;
            st_wr_q  <= '0;
            st_cnt_q <= '0;
        end else begin
            ld_rd_q  <= ld_rd_d;
            ld_wr_q  <= ld_wr_d;
            ld_cnt_q <= ld_cnt_d;
            st_rd_q  <= st_rd_d;
            st_wr_q  <= st_wr_d;
            st_cnt_q <= st_cnt_d;
        end
    end

    // Storage needs no reset: entries are only visible through the counters.
    always_ff @(posedge Clk) begin
        if (!Rest && ld_enq) ld_mem_q[ld_wr_q] <= bus.AguLoadAddr;
        if (!Rest && st_enq) st_mem_q[st_wr_q] <= bus.AguStoreAddr;
    end
endmodule

// File: tb/tb_dcache_lsu_issue.sv
// Directed bench for dcache_lsu_issue: stimulus pushes expected issue order,
// a negedge monitor pops and compares every accepted load/store.
module tb_dcache_lsu_issue;
    logic clk;
    logic rest;
    int   checks;
    int   failures;

    logic [31:0] exp_load[$];
    logic [31:0] exp_store[$];

    dcache_lsu_issue_if #(.ADDR_W(32), .CNT_W(3)) bus ();

    dcache_lsu_issue #(.ADDR_W(32), .DEPTH(4), .CNT_W(3)) dut (
        .Clk  (clk),
        .Rest (rest),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.DcacheStop    = 1'b0;
        bus.DcacheFlash   = 1'b0;
        bus.AguLoadValid  = 1'b0;
        bus.AguLoadAddr   = '0;
        bus.AguStoreValid = 1'b0;
        bus.AguStoreAddr  = '0;
        bus.LoadReq       = 1'b0;
        bus.StoreReq      = 1'b0;
    endtask

    // Scoreboard monitor: sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (!rest && bus.LoadAble && bus.LoadReq) begin
            if (exp_load.size() == 0) chk("load_unexpected", bus.LoadPhyAddr, 32'hdead_beef);
            else chk("load_order", bus.LoadPhyAddr, exp_load.pop_front());
        end
        if (!rest && bus.StoreAble && bus.StoreReq) begin
            if (exp_store.size() == 0) chk("store_unexpected", bus.StorePhyAddr, 32'hdead_beef);
            else chk("store_order", bus.StorePhyAddr, exp_store.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        idle_inputs();
        rest = 1'b1;
        repeat (2) tick();
        rest = 1'b0;
        #1;
        chk("rst_load_able", bus.LoadAble, 0);
        chk("rst_store_able", bus.StoreAble, 0);
        chk("rst_load_ready", bus.AguLoadReady, 1);
        chk("rst_store_ready", bus.AguStoreReady, 1);
        chk("rst_load_addr", bus.LoadPhyAddr, 0);
        chk("rst_store_addr", bus.StorePhyAddr, 0);
        chk("rst_load_cnt", bus.LoadCount, 0);
        chk("rst_store_cnt", bus.StoreCount, 0);

        // Streaming loads with constant acceptance.
        bus.LoadReq = 1'b1;
        bus.AguLoadValid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.AguLoadAddr = 32'h1000 + 32'(4 * k);
            exp_load.push_back(bus.AguLoadAddr);
            tick();
        end
        bus.AguLoadValid = 1'b0;
        tick();
        chk("stream_load_cnt", bus.LoadCount, 0);
        bus.LoadReq = 1'b0;

        // Fill store queue, reject 5th, drain, refill across wrapped pointers.
        bus.AguStoreValid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.AguStoreAddr = 32'h3000 + 32'(16 * k);
            exp_store.push_back(bus.AguStoreAddr);
            tick();
        end
        bus.AguStoreAddr = 32'h3040;
        #1;
        chk("full_store_cnt", bus.StoreCount, 4);
        chk("full_store_ready", bus.AguStoreReady, 0);
        tick();
        bus.AguStoreValid = 1'b0;
        #1;
        chk("full_reject_cnt", bus.StoreCount, 4);
        bus.StoreReq = 1'b1;
        repeat (4) tick();
        chk("drain_store_cnt", bus.StoreCount, 0);
        bus.AguStoreValid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.AguStoreAddr = 32'h3100 + 32'(16 * k);
            exp_store.push_back(bus.AguStoreAddr);
            tick();
        end
        bus.AguStoreValid = 1'b0;
        tick();
        chk("refill_store_cnt", bus.StoreCount, 0);
        bus.StoreReq = 1'b0;

        // Same-word store blocks load until the store has issued.
        bus.AguStoreValid = 1'b1;
        bus.AguStoreAddr  = 32'h2008;
        exp_store.push_back(32'h2008);
        tick();
        bus.AguStoreValid = 1'b0;
        bus.AguLoadValid  = 1'b1;
        bus.AguLoadAddr   = 32'h200A;
        bus.LoadReq       = 1'b1;
        exp_load.push_back(32'h200A);
        tick();
        bus.AguLoadValid = 1'b0;
        #1;
        chk("hazard_block", bus.LoadAble, 0);
        chk("hazard_store_able", bus.StoreAble, 1);
        tick();
        bus.StoreReq = 1'b1;
        #1;
        chk("hazard_issuing_store", bus.LoadAble, 0);
        chk("hazard_load_cnt", bus.LoadCount, 1);
        tick();
        bus.StoreReq = 1'b0;
        #1;
        chk("hazard_release", bus.LoadAble, 1);
        chk("hazard_release_addr", bus.LoadPhyAddr, 32'h200A);
        tick();
        chk("hazard_load_drained", bus.LoadCount, 0);
        bus.AguStoreValid = 1'b1;
        bus.AguStoreAddr  = 32'h2008;
        bus.AguLoadValid  = 1'b1;
        bus.AguLoadAddr   = 32'h200C;
        exp_store.push_back(32'h2008);
        exp_load.push_back(32'h200C);
        tick();
        bus.AguStoreValid = 1'b0;
        bus.AguLoadValid  = 1'b0;
        #1;
        chk("no_hazard_able", bus.LoadAble, 1);
        chk("no_hazard_addr", bus.LoadPhyAddr, 32'h200C);
        tick();
        bus.LoadReq  = 1'b0;
        bus.StoreReq = 1'b1;
        tick();
        bus.StoreReq = 1'b0;
        #1;
        chk("hazard_store_drained", bus.StoreCount, 0);

        // Stall holds issue and contents.
        bus.AguLoadValid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            bus.AguLoadAddr = 32'h4000 + 32'(4 * k);
            exp_load.push_back(bus.AguLoadAddr);
            tick();
        end
        bus.AguLoadValid = 1'b0;
        bus.DcacheStop   = 1'b1;
        bus.LoadReq      = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stop_able", bus.LoadAble, 0);
            tick();
            chk("stop_cnt", bus.LoadCount, 2);
        end
        bus.DcacheStop = 1'b0;
        repeat (2) tick();
        chk("stop_drain_cnt", bus.LoadCount, 0);
        bus.LoadReq = 1'b0;

        // Flush with a colliding enqueue.
        bus.AguLoadValid = 1'b1;
        bus.AguStoreValid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.AguLoadAddr  = 32'h5000 + 32'(4 * k);
            bus.AguStoreAddr = 32'h6000 + 32'(16 * k);
            bus.AguStoreValid = (k < 2);
            tick();
        end
        bus.AguStoreValid = 1'b0;
        bus.AguLoadAddr   = 32'h500C;
        bus.DcacheFlash   = 1'b1;
        bus.LoadReq       = 1'b1;
        bus.StoreReq      = 1'b1;
        #1;
        chk("flash_load_able", bus.LoadAble, 0);
        chk("flash_store_able", bus.StoreAble, 0);
        chk("flash_pre_store_cnt", bus.StoreCount, 2);
        tick();
        idle_inputs();
        #1;
        chk("flash_load_cnt", bus.LoadCount, 0);
        chk("flash_store_cnt", bus.StoreCount, 0);
        chk("flash_load_addr", bus.LoadPhyAddr, 0);
        chk("flash_store_addr", bus.StorePhyAddr, 0);

        // Steady-state enqueue+issue at count 2, then reset mid-stream.
        bus.AguLoadValid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            bus.AguLoadAddr = 32'h7000 + 32'(4 * k);
            exp_load.push_back(bus.AguLoadAddr);
            tick();
        end
        bus.LoadReq = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus.AguLoadAddr = 32'h7008 + 32'(4 * k);
            exp_load.push_back(bus.AguLoadAddr);
            tick();
            chk("steady_cnt", bus.LoadCount, 2);
        end
        bus.LoadReq     = 1'b0;
        bus.AguLoadAddr = 32'h7100;
        rest = 1'b1;
        tick();
        rest = 1'b0;
        idle_inputs();
        exp_load.delete();
        #1;
        chk("midrst_load_cnt", bus.LoadCount, 0);
        chk("midrst_load_able", bus.LoadAble, 0);
        chk("midrst_load_addr", bus.LoadPhyAddr, 0);
        chk("midrst_load_ready", bus.AguLoadReady, 1);

        repeat (2) tick();
        chk("sb_load_empty", 32'(exp_load.size()), 0);
        chk("sb_store_empty", 32'(exp_store.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
